// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states, strobe bus.
package mem_access_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [3:0] strb_t;

    // funct3 encodings for loads/stores
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_e;

    // access size, funct3[1:0]
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if #(
    parameter int unsigned DATA_W = 32
);
    import mem_access_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    strb_t             mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane formatting: store strobes/replication, misalignment detect,
// and load lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]      req_off,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] store_data,
    output strb_t           wstrb,
    output logic [XLEN-1:0] wdata,
    output logic            misaligned,
    input  logic [1:0]      ld_off,
    input  logic [2:0]      ld_funct3,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // store strobes, lane-replicated data and alignment check for the incoming request
    always_comb begin
        wstrb      = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (req_size)
            SZ_B: begin
                wstrb = 4'b0001 << req_off;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                wstrb      = 4'b0011 << req_off;
                wdata      = {2{store_data[15:0]}};
                misaligned = req_off[0];
            end
            default: begin
                wstrb      = 4'b1111;
                wdata      = store_data;
                misaligned = (req_off != 2'b00);
            end
        endcase
    end

    // pick the addressed lane of the read word and extend it; funct3[2] selects zero-extension
    always_comb begin
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3[1:0])
            SZ_B:    ld_data = ld_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = ld_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, and registers the MEM_WB latch.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] storeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rdAddr,
    input  logic              regWrite,
    mem_access_stage_if.master mem,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_regWrite,
    output logic              mem_err
);

    // The counter starts at 0 on the first BUSY cycle, so matching TIMEOUT-1
    // without ack gives exactly TIMEOUT cycles of mem_req before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_e state, state_next;

    logic [7:0]        cnt;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    strb_t             req_wstrb;
    logic [1:0]        lat_off;
    logic [2:0]        lat_f3;
    logic [4:0]        lat_rd;
    logic              lat_rw;
    logic              lat_load;

    logic              is_mem;
    logic              to_hit;
    logic              ev_accept, ev_pass, ev_mis, ev_done, ev_tmo;

    strb_t             fmt_wstrb;
    logic [DATA_W-1:0] fmt_wdata;
    logic              fmt_mis;
    logic [DATA_W-1:0] ld_data;

    mem_lane_align u_lane (
        .req_off    (aluResult[1:0]),
        .req_size   (funct3[1:0]),
        .store_data (storeData),
        .wstrb      (fmt_wstrb),
        .wdata      (fmt_wdata),
        .misaligned (fmt_mis),
        .ld_off     (lat_off),
        .ld_funct3  (lat_f3),
        .rdata      (mem.mem_rdata),
        .ld_data    (ld_data)
    );

    assign is_mem = memRead | memWrite;
    assign to_hit = (cnt == TO_LAST);

    assign mem.mem_req   = (state == MEM_BUSY);
    assign mem.mem_we    = req_we;
    assign mem.mem_addr  = req_addr;
    assign mem.mem_wdata = req_wdata;
    assign mem.mem_wstrb = req_wstrb;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MEM_IDLE;
        else        state <= state_next;
    end

    // next-state: accept an aligned access in IDLE, leave BUSY on ack or timeout
    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (ev_accept)         state_next = MEM_BUSY;
            MEM_BUSY: if (ev_done || ev_tmo) state_next = MEM_IDLE;
            default:                         state_next = MEM_IDLE;
        endcase
    end

    // stall and per-cycle events; ack beats timeout, nothing is asserted during reset
    always_comb begin
        stall     = 1'b0;
        ev_accept = 1'b0;
        ev_pass   = 1'b0;
        ev_mis    = 1'b0;
        ev_done   = 1'b0;
        ev_tmo    = 1'b0;
        if (rst_n) begin
            case (state)
                MEM_IDLE: begin
                    if (in_valid) begin
                        if (!is_mem)      ev_pass = 1'b1;
                        else if (fmt_mis) ev_mis  = 1'b1;
                        else begin
                            ev_accept = 1'b1;
                            stall     = 1'b1;
                        end
                    end
                end
                MEM_BUSY: begin
                    if (mem.mem_ack)  ev_done = 1'b1;
                    else if (to_hit)  ev_tmo  = 1'b1;
                    else              stall   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // request fields, timeout counter and MEM_WB latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            lat_off      <= '0;
            lat_f3       <= '0;
            lat_rd       <= '0;
            lat_rw       <= 1'b0;
            lat_load     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_regWrite <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            mem_err   <= 1'b0;
            if (ev_accept) begin
                cnt       <= '0;
                req_we    <= memWrite & ~memRead;
                req_addr  <= word_addr(aluResult);
                req_wdata <= fmt_wdata;
                req_wstrb <= memRead ? '0 : fmt_wstrb;
                lat_off   <= aluResult[1:0];
                lat_f3    <= funct3;
                lat_rd    <= rdAddr;
                lat_rw    <= regWrite;
                lat_load  <= memRead;
            end else if (ev_pass) begin
                out_valid    <= 1'b1;
                out_data     <= aluResult;
                out_rd       <= rdAddr;
                out_regWrite <= regWrite;
            end else if (ev_mis) begin
                out_valid    <= 1'b1;
                out_data     <= aluResult;
                out_rd       <= rdAddr;
                out_regWrite <= 1'b0;
                mem_err      <= 1'b1;
            end else if (ev_done) begin
                out_valid    <= 1'b1;
                out_data     <= ld_data;
                out_rd       <= lat_rd;
                out_regWrite <= lat_load & lat_rw;
                req_we       <= 1'b0;
                req_wstrb    <= '0;
            end else if (ev_tmo) begin
                out_valid    <= 1'b1;
                out_data     <= '0;
                out_rd       <= lat_rd;
                out_regWrite <= 1'b0;
                mem_err      <= 1'b1;
                req_we       <= 1'b0;
                req_wstrb    <= '0;
            end else if (state == MEM_BUSY) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage directly downstream of the ALU stage. It consumes the ALU_MEM latch: the ALU result and the forwarded rs2 store data.
- Performs load/store transactions on a single-port data memory using a req/ack handshake. Handles byte/half/word alignment, store strobes and load sign/zero extension.
- Registers the writeback value into the MEM_WB latch. Stalls upstream while a memory access is outstanding.

Parameters:
- DATA_W, 32, datapath width; matches `DataSize.
- TIMEOUT, 255, maximum wait cycles for mem_ack before the access is aborted (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU_MEM latch holds a valid instruction.
- aluResult  in  32  ALU output; effective address for load/store, writeback data otherwise.
- storeData  in  32  forwarded rs2 value for stores.
- memRead  in  1  instruction is a load.
- memWrite  in  1  instruction is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdAddr  in  5  destination register.
- regWrite  in  1  instruction writes rd.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  request completed this cycle; rdata valid.
- mem_rdata  in  32  read word.
- stall  out  1  hold ALU_MEM and all upstream latches.
- out_valid  out  1  MEM_WB latch valid.
- out_data  out  32  writeback value.
- out_rd  out  5  destination register.
- out_regWrite  out  1  writeback enable.
- mem_err  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, mem_wstrb, out_valid, out_regWrite and mem_err = 0; mem_addr, mem_wdata, out_data and out_rd = 0; timeout counter = 0.
- Reset asserted mid-access abandons the transaction. No output completes and mem_req drops immediately.
- FSM states: IDLE and BUSY.
- IDLE, in_valid with memRead=memWrite=0: pass-through. Next edge sets out_valid=1, out_data=aluResult, out_rd=rdAddr, out_regWrite=regWrite. Latency 1; stall=0.
- IDLE, in_valid with a memory op, aligned:
  - stall=1 combinationally.
  - Next edge: latch address, size, rd and regWrite; go to BUSY; assert mem_req with mem_we, mem_addr, mem_wdata and mem_wstrb.
  - out_valid=0 on that edge.
- IDLE, in_valid with a memory op, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0):
  - No request is issued; stall=0.
  - Next edge: out_valid=1, out_regWrite=0, mem_err=1 for one cycle.
- memRead and memWrite both high: the load takes priority and the write is ignored.
- BUSY:
  - mem_req and all request fields are held stable until mem_ack.
  - stall = !mem_ack.
  - On the ack cycle: next edge returns to IDLE with mem_req=0 and out_valid=1. out_regWrite is the latched regWrite for loads, 0 for stores.
  - Total load latency = cycles to ack + 1.
- BUSY timeout: the counter increments each cycle without ack. When count reaches TIMEOUT:
  - stall drops that cycle.
  - Next edge: IDLE, mem_req=0, out_valid=1, out_regWrite=0, mem_err=1.
  - The counter clears on every IDLE→BUSY transition.
- An ack arriving in the same cycle as the timeout wins; the access completes normally.
- mem_ack while in IDLE is ignored.
- Store formatting:
  - SB: wstrb = 4'b0001<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: wstrb = 4'b0011<<addr[1:0]; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'b1111.
  - mem_wstrb = 0 on reads.
- Load formatting: select the byte/half lane by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- Output latch semantics: out_valid is 0 in every cycle not described above (bubble). The output latch updates only on completion edges and otherwise holds its value with out_valid=0.

Decomposition:
- Shared define.v gains:
  - funct3 size codes: `MemB, `MemH, `MemW, `MemBU, `MemHU.
  - State encodings `MemIdle and `MemBusy.
  - `StrbBus [3:0].
- One combinational sub-module, mem_lane_align, contains the store wstrb/wdata formatting, the load extract/extend and the misalignment detect. The FSM and latches stay in mem_access_stage.

Test Plan:
- ADD pass-through: aluResult=0x1234, rd=5, regWrite=1 -> next cycle out_valid=1, out_data=0x1234, out_rd=5, stall never asserted.
- LB addr=0x103, mem_rdata=0x80FFFFFF, ack 3 cycles after req -> mem_addr=0x100, stall high for 4 cycles, out_data=0xFFFFFF80; repeat with LBU -> 0x00000080.
- SH addr=0x202, storeData=0xDEADBEEF, immediate ack -> mem_we=1, mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, out_regWrite=0.
- LW addr=0x105 -> mem_req never asserted, mem_err one-cycle pulse, out_valid=1, out_regWrite=0.
- LW with no ack and TIMEOUT=4 -> mem_req high 4 cycles then drops, mem_err pulse, stall released; ack and timeout in same cycle -> normal completion, no mem_err.
- rst_n pulled low while BUSY -> mem_req, out_valid and stall go 0 asynchronously; after release, a new LW completes normally.
